// File: rtl/add_sub_defs.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding and default width.
package add_sub_defs;
    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;
endpackage

// File: rtl/full_adder_bit.sv
// Combinational 1-bit full adder; the single arithmetic cell reused on every serial step.
module full_adder_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);
    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);
endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial two's-complement add/subtract, LSB first, one bit per clock through a
// registered-carry full adder; start/done handshake around an IDLE/RUN/DONE FSM.
module serial_add_sub
    import add_sub_defs::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o
);
    state_e             state_q;
    logic [WIDTH-1:0]   sa_q, sb_q, res_q, sum_q;
    logic [WIDTH-1:0]   res_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               c_q, carry_q, ovf_q, busy_q, done_q;
    logic               fa_s, fa_c;

    full_adder_bit u_fa (
        .a_i   (sa_q[0]),
        .b_i   (sb_q[0]),
        .cin_i (c_q),
        .sum_o (fa_s),
        .cout_o(fa_c)
    );

    // New bit enters at the MSB so after WIDTH steps bit 0 sits at the LSB.
    assign res_d = {fa_s, res_q[WIDTH-1:1]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        sa_q    <= a_i;
                        sb_q    <= b_i ^ {WIDTH{sub_i}};
                        c_q     <= sub_i;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    sa_q  <= sa_q >> 1;
                    sb_q  <= sb_q >> 1;
                    res_q <= res_d;
                    c_q   <= fa_c;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        // c_q here is the carry into the MSB.
                        sum_q   <= res_d;
                        carry_q <= fa_c;
                        ovf_q   <= c_q ^ fa_c;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign sum_o      = sum_q;
    assign carry_o    = carry_q;
    assign overflow_o = ovf_q;
endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub at WIDTH=4 and WIDTH=8 with directed vectors.
module tb_serial_add_sub;
    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       start4 = 1'b0, sub4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, carry4, ovf4;
    logic [3:0] sum4;

    logic       start8 = 1'b0, sub8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, carry8, ovf8;
    logic [7:0] sum8;

    int n_cmp = 0;
    int n_bad = 0;

    logic [5:0] q4[$];
    logic [9:0] q8[$];

    always #5 clk = ~clk;

    serial_add_sub #(.WIDTH(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start4), .sub_i(sub4), .a_i(a4), .b_i(b4),
        .busy_o(busy4), .done_o(done4), .sum_o(sum4), .carry_o(carry4), .overflow_o(ovf4)
    );

    serial_add_sub #(.WIDTH(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start8), .sub_i(sub8), .a_i(a8), .b_i(b8),
        .busy_o(busy8), .done_o(done8), .sum_o(sum8), .carry_o(carry8), .overflow_o(ovf8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done4 !== 1'b0) begin
            if (q4.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL w4_unexpected_done: got done=%b with no op outstanding, sum=%h", done4, sum4);
            end else begin
                logic [5:0] e;
                e = q4.pop_front();
                chk("w4_result", {28'd0, sum4, carry4, ovf4}, {28'd0, e});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done8 !== 1'b0) begin
            if (q8.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL w8_unexpected_done: got done=%b with no op outstanding, sum=%h", done8, sum8);
            end else begin
                logic [9:0] e;
                e = q8.pop_front();
                chk("w8_result", {22'd0, sum8, carry8, ovf8}, {22'd0, e});
            end
        end
    end

    // Operands are scrambled after the start edge to prove they were captured.
    task automatic op4(input logic s, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] es, input logic ec, input logic ev);
        q4.push_back({es, ec, ev});
        @(negedge clk); start4 = 1'b1; sub4 = s; a4 = a; b4 = b;
        @(negedge clk); start4 = 1'b0; sub4 = ~s; a4 = ~a; b4 = ~b;
        repeat (4) @(negedge clk);
    endtask

    task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] es, input logic ec, input logic ev);
        q8.push_back({es, ec, ev});
        @(negedge clk); start8 = 1'b1; sub8 = s; a8 = a; b8 = b;
        @(negedge clk); start8 = 1'b0; sub8 = ~s; a8 = ~a; b8 = ~b;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int busy_cnt;

        // Async reset with no clock edge yet.
        #2 rst = 1'b1;
        #1;
        chk("rst_busy4", {31'd0, busy4}, 32'd0);
        chk("rst_done4", {31'd0, done4}, 32'd0);
        chk("rst_out4", {27'd0, sum4, carry4}, 32'd0);
        chk("rst_ovf4", {31'd0, ovf4}, 32'd0);
        chk("rst_out8", {21'd0, busy8, done8, sum8, carry8, ovf8}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle_busy_done4", {30'd0, busy4, done4}, 32'd0);
        chk("idle_busy_done8", {30'd0, busy8, done8}, 32'd0);

        // 5+3: latency and busy length.
        q4.push_back({4'h8, 1'b0, 1'b1});
        @(negedge clk); start4 = 1'b1; sub4 = 1'b0; a4 = 4'd5; b4 = 4'd3;
        @(negedge clk); start4 = 1'b0; a4 = 4'hF; b4 = 4'hF; sub4 = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy4 !== 1'b1) break;
            busy_cnt++;
            @(negedge clk);
        end
        chk("w4_busy_cycles", busy_cnt, 32'd4);
        chk("w4_done_latency", {31'd0, done4}, 32'd1);

        op4(1'b1, 4'd3, 4'd5, 4'hE, 1'b0, 1'b0);
        op4(1'b0, 4'hF, 4'h1, 4'h0, 1'b1, 1'b0);
        op4(1'b1, 4'h8, 4'h1, 4'h7, 1'b1, 1'b1);
        op4(1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);

        // 6+7 with stray starts in RUN and in DONE.
        q4.push_back({4'hD, 1'b0, 1'b1});
        @(negedge clk); start4 = 1'b1; sub4 = 1'b0; a4 = 4'd6; b4 = 4'd7;
        @(negedge clk); start4 = 1'b0;
        @(negedge clk); start4 = 1'b1; a4 = 4'd1; b4 = 4'd1;
        @(negedge clk); start4 = 1'b0;
        @(negedge clk);
        @(negedge clk); start4 = 1'b1;
        chk("w4_held_sum", {28'd0, sum4}, 32'hD);
        @(negedge clk); start4 = 1'b0;
        repeat (3) @(negedge clk);
        chk("w4_no_retrigger", {30'd0, busy4, done4}, 32'd0);

        // Reset in the middle of RUN aborts the op.
        @(negedge clk); start4 = 1'b1; sub4 = 1'b0; a4 = 4'd9; b4 = 4'd1;
        @(negedge clk); start4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy4", {31'd0, busy4}, 32'd0);
        chk("abort_out4", {26'd0, done4, sum4, carry4}, 32'd0);
        @(negedge clk); rst = 1'b0;
        repeat (6) @(negedge clk);
        op4(1'b0, 4'd2, 4'd2, 4'd4, 1'b0, 1'b0);

        // WIDTH=8 variants.
        op8(1'b0, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0);
        op8(1'b1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0);
        op8(1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        op8(1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
        op8(1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);

        repeat (5) @(negedge clk);
        chk("w4_pending", q4.size(), 32'd0);
        chk("w8_pending", q8.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
